// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse keyer.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MARK = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } morse_state_t;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int SYM_GAP_UNITS  = 1;
    localparam int WORD_GAP_UNITS = 7;
    localparam int MORSE_MAX_LEN  = 5;

    // pat is right-aligned: bit len-1 is the first symbol, 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
        logic       is_space;
        logic       valid;
    } morse_code_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII to Morse pattern lookup.
// MORSE_LOWERCASE_EN folds 'a'-'z' onto 'A'-'Z'.
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0]  ascii_i,
    output morse_code_t code_o
);

    logic [7:0] ch_s;
    logic [7:0] lp_s;

    // Case folding and table lookup; lp_s packs {len, pat}.
    always_comb begin
`ifdef MORSE_LOWERCASE_EN
        ch_s = ((ascii_i >= 8'h61) && (ascii_i <= 8'h7A)) ? (ascii_i - 8'h20) : ascii_i;
`else
        ch_s = ascii_i;
`endif
        lp_s = 8'h00;
        case (ch_s)
            8'h41: lp_s = {3'd2, 5'b00001}; // A .-
            8'h42: lp_s = {3'd4, 5'b01000}; // B -...
            8'h43: lp_s = {3'd4, 5'b01010};
            8'h44: lp_s = {3'd3, 5'b00100};
            8'h45: lp_s = {3'd1, 5'b00000};
            8'h46: lp_s = {3'd4, 5'b00010};
            8'h47: lp_s = {3'd3, 5'b00110};
            8'h48: lp_s = {3'd4, 5'b00000};
            8'h49: lp_s = {3'd2, 5'b00000};
            8'h4A: lp_s = {3'd4, 5'b00111};
            8'h4B: lp_s = {3'd3, 5'b00101};
            8'h4C: lp_s = {3'd4, 5'b00100};
            8'h4D: lp_s = {3'd2, 5'b00011};
            8'h4E: lp_s = {3'd2, 5'b00010};
            8'h4F: lp_s = {3'd3, 5'b00111};
            8'h50: lp_s = {3'd4, 5'b00110};
            8'h51: lp_s = {3'd4, 5'b01101};
            8'h52: lp_s = {3'd3, 5'b00010};
            8'h53: lp_s = {3'd3, 5'b00000};
            8'h54: lp_s = {3'd1, 5'b00001};
            8'h55: lp_s = {3'd3, 5'b00001};
            8'h56: lp_s = {3'd4, 5'b00001};
            8'h57: lp_s = {3'd3, 5'b00011};
            8'h58: lp_s = {3'd4, 5'b01001};
            8'h59: lp_s = {3'd4, 5'b01011};
            8'h5A: lp_s = {3'd4, 5'b01100};
            8'h30: lp_s = {3'd5, 5'b11111};
            8'h31: lp_s = {3'd5, 5'b01111};
            8'h32: lp_s = {3'd5, 5'b00111};
            8'h33: lp_s = {3'd5, 5'b00011};
            8'h34: lp_s = {3'd5, 5'b00001};
            8'h35: lp_s = {3'd5, 5'b00000};
            8'h36: lp_s = {3'd5, 5'b10000};
            8'h37: lp_s = {3'd5, 5'b11000};
            8'h38: lp_s = {3'd5, 5'b11100};
            8'h39: lp_s = {3'd5, 5'b11110};
            default: lp_s = 8'h00;
        endcase
        code_o.len      = lp_s[7:5];
        code_o.pat      = lp_s[4:0];
        code_o.is_space = (ch_s == 8'h20);
        code_o.valid    = (ch_s == 8'h20) || (lp_s[7:5] != 3'd0);
    end

endmodule

// File: rtl/morse_generator.sv
// Plays one ASCII character as an International Morse keying signal.
// Lowercase support is selected by MORSE_LOWERCASE_EN (see morse_lut).
module morse_generator
    import morse_pkg::*;
#(
    parameter int MORSE_CYCLES = 10_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] ascii_i,
    input  logic       en_i,
    output logic       morse_o,
    output logic       done_o
);

    localparam int CW = $clog2(7 * MORSE_CYCLES);
    localparam logic [CW-1:0] DOT_LIM  = CW'(DOT_UNITS * MORSE_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LIM = CW'(DASH_UNITS * MORSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LIM  = CW'(SYM_GAP_UNITS * MORSE_CYCLES - 1);
    localparam logic [CW-1:0] WORD_LIM = CW'(WORD_GAP_UNITS * MORSE_CYCLES - 1);

    morse_state_t  state_r;
    logic [7:0]    char_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] lim_r;
    logic [4:0]    sym_r;
    logic [2:0]    len_r;
    logic [2:0]    idx_r;
    logic          morse_r;
    logic          done_r;
    morse_code_t   code_s;
    logic [4:0]    load_sym_s;

    morse_lut u_lut (
        .ascii_i (char_r),
        .code_o  (code_s)
    );

    // Left-align the pattern so the current symbol is always sym_r[4].
    assign load_sym_s = 5'(code_s.pat << (3'(MORSE_MAX_LEN) - code_s.len));

    // Main FSM: acceptance, symbol sequencing, unit counter, registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            char_r  <= 8'h00;
            cnt_r   <= '0;
            lim_r   <= '0;
            sym_r   <= 5'd0;
            len_r   <= 3'd0;
            idx_r   <= 3'd0;
            morse_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en_i) begin
                        char_r  <= ascii_i;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_r <= '0;
                    sym_r <= load_sym_s;
                    len_r <= code_s.len;
                    idx_r <= 3'd1;
                    if (!code_s.valid) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (code_s.is_space) begin
                        idx_r   <= 3'd0;
                        lim_r   <= WORD_LIM;
                        state_r <= ST_GAP;
                    end else begin
                        lim_r   <= load_sym_s[4] ? DASH_LIM : DOT_LIM;
                        morse_r <= 1'b1;
                        state_r <= ST_MARK;
                    end
                end
                ST_MARK: begin
                    if (cnt_r == lim_r) begin
                        cnt_r   <= '0;
                        lim_r   <= GAP_LIM;
                        morse_r <= 1'b0;
                        state_r <= ST_GAP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r == lim_r) begin
                        cnt_r <= '0;
                        if (idx_r < len_r) begin
                            idx_r   <= idx_r + 3'd1;
                            sym_r   <= {sym_r[3:0], 1'b0};
                            lim_r   <= sym_r[3] ? DASH_LIM : DOT_LIM;
                            morse_r <= 1'b1;
                            state_r <= ST_MARK;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: begin
                    morse_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign morse_o = morse_r;
    assign done_o  = done_r;

endmodule

// File: tb/tb_morse_generator.sv
// Directed, table-driven bench for morse_generator with MORSE_CYCLES = 2.
module tb_morse_generator;

    localparam int MC = 2;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [7:0] ascii_i;
    logic       en_i;
    logic       morse_o;
    logic       done_o;

    int errors = 0;
    int checks = 0;

    morse_generator #(.MORSE_CYCLES(MC)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .ascii_i (ascii_i),
        .en_i    (en_i),
        .morse_o (morse_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        string      sym;     // '.', '-' or ' ' (word gap); empty = unsupported
        int         done_at; // edges after the accept edge until done_o is high
        logic       disturb;
    } vec_t;

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    // Accept ch at the next edge and check every cycle through the IDLE after done.
    task automatic play(input vec_t v);
        logic [127:0] wave;
        int n;
        wave = '0;
        n = 1;
        for (int i = 0; i < v.sym.len(); i++) begin
            if (v.sym[i] == "-") begin
                for (int j = 0; j < 3 * MC; j++) wave[n + j] = 1'b1;
                n += 4 * MC;
            end else if (v.sym[i] == ".") begin
                for (int j = 0; j < MC; j++) wave[n + j] = 1'b1;
                n += 2 * MC;
            end else begin
                n += 7 * MC;
            end
        end
        @(negedge clk);
        ascii_i = v.ch;
        en_i    = 1'b1;
        @(posedge clk);
        #1 en_i = 1'b0;
        for (int k = 1; k <= v.done_at + 1; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("morse_%02h", v.ch), k, morse_o, (k < v.done_at) ? wave[k] : 1'b0);
            chk($sformatf("done_%02h", v.ch), k, done_o, (k == v.done_at));
            if (v.disturb && k < v.done_at) begin
                ascii_i = 8'($urandom);
                en_i    = k[0];
            end else begin
                en_i = 1'b0;
            end
        end
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{8'h41, ".-",    13, 1'b0};
        vecs[1]  = '{8'h39, "----.", 37, 1'b0};
        vecs[2]  = '{8'h45, ".",      5, 1'b0};
        vecs[3]  = '{8'h54, "-",      9, 1'b0};
        vecs[4]  = '{8'h30, "-----", 41, 1'b0};
        vecs[5]  = '{8'h5A, "--..",  25, 1'b0};
        vecs[6]  = '{8'h20, " ",     15, 1'b0};
        vecs[7]  = '{8'h23, "",       1, 1'b0};
        vecs[8]  = '{8'h40, "",       1, 1'b0};
        vecs[9]  = '{8'h5B, "",       1, 1'b0};
        vecs[10] = '{8'h2F, "",       1, 1'b0};
        vecs[11] = '{8'h3A, "",       1, 1'b0};
        vecs[12] = '{8'h41, ".-",    13, 1'b1};
`ifdef MORSE_LOWERCASE_EN
        vecs[13] = '{8'h61, ".-",    13, 1'b0};
`else
        vecs[13] = '{8'h61, "",       1, 1'b0};
`endif

        // Reset with a pending request: nothing may start.
        reset_i = 1'b1;
        en_i    = 1'b1;
        ascii_i = 8'h41;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_morse", k, morse_o, 1'b0);
            chk("rst_done", k, done_o, 1'b0);
        end
        @(negedge clk);
        reset_i = 1'b0;
        en_i    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("idle_morse", k, morse_o, 1'b0);
            chk("idle_done", k, done_o, 1'b0);
        end

        for (int i = 0; i < 14; i++) play(vecs[i]);

        // Back-to-back 'E' with en_i held high.
        @(negedge clk);
        ascii_i = 8'h45;
        en_i    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 12) en_i = 1'b0;
            chk("b2b_done", k, done_o, (k == 5) || (k == 12));
            chk("b2b_morse", k, morse_o, (k == 1) || (k == 2) || (k == 8) || (k == 9));
        end
        repeat (2) @(posedge clk);

        // Reset in the middle of the dash of 'A'.
        @(negedge clk);
        ascii_i = 8'h41;
        en_i    = 1'b1;
        @(posedge clk);
        #1 en_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
        end
        chk("dash_morse", 6, morse_o, 1'b1);
        @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_morse", 7, morse_o, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            chk("rstmid_morse_after", k, morse_o, 1'b0);
            chk("rstmid_done_after", k, done_o, 1'b0);
        end

        // Still functional after the mid-character reset.
        play(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_generator.md
# morse_generator

Converts one ASCII character into an on/off Morse keying signal, using standard International Morse timing in units of `MORSE_CYCLES` clock cycles. It sits between a character source (e.g. a UART receive path) and a keying output (LED, buzzer or pin). The upstream logic presents a character with an enable. The block plays the character, then pulses `done_o`.

## Interface
Parameters:
- `MORSE_CYCLES`, default 10_000_000, clock cycles per Morse unit (1 unit = 100 ms at 100 MHz). Must be ≥ 1.

Ports:
- `clk_i` input 1: the single clock; all logic is rising-edge.
- `reset_i` input 1: reset, synchronous and active-high.
- `ascii_i` input 8: character to send; sampled only on acceptance.
- `en_i` input 1: request; level-sensitive, sampled only in IDLE.
- `morse_o` output 1: keying output; 1 = tone/mark, 0 = space.
- `done_o` output 1: one-cycle pulse when the character has finished.

## Operation
- **States:**
  - IDLE: waits for a request.
  - LOAD: looks up the pattern.
  - MARK: `morse_o` = 1 for the current symbol.
  - GAP: `morse_o` = 0 between/after symbols.
  - DONE: pulses `done_o`.
- **Acceptance:** in IDLE with `en_i`=1 at a rising edge, the block latches `ascii_i` and moves to LOAD. `ascii_i` and `en_i` are ignored from LOAD until the block is back in IDLE.
- **Lookup result:** symbol count `len` (3 bits, 0–5) and pattern `pat` (5 bits). `pat` is read MSB-first over `len` symbols; 1 = dash, 0 = dot.
  - 'A'–'Z' (0x41–0x5A) and '0'–'9' (0x30–0x39) use the International Morse table, e.g. 'A' = .-, 'E' = ., '0' = -----, '9' = ----.
  - Space (0x20): word gap, `len`=0.
  - Every other code is unsupported, `len`=0.
- **Symbol durations:**
  - Dot: MARK for 1 unit, then GAP for 1 unit.
  - Dash: MARK for 3 units, then GAP for 1 unit.
  - The trailing 1-unit gap also follows the final symbol.
- **Space:** GAP for 7 units, no MARK.
- **Unsupported character:** LOAD goes directly to DONE; `morse_o` stays 0.
- After the last gap: DONE for 1 cycle with `done_o`=1, then IDLE.
- If `en_i` is still high in the first IDLE cycle, the current `ascii_i` is accepted immediately. Back-to-back characters are allowed; there is no inter-character gap beyond the trailing 1 unit.
- **Unit counter:** width `$clog2(7*MORSE_CYCLES)`. It counts 0..N·`MORSE_CYCLES`−1 and reloads on every MARK/GAP entry.

## Timing
- **Reset:** `reset_i`=1 at an edge forces IDLE, `morse_o`=0, `done_o`=0 and clears the counter and latched character, including mid-character. Reset has priority over acceptance.
- **Latency:** accept edge → LOAD (1 cycle) → `morse_o` rises at the start of the second cycle after acceptance.
- MARK/GAP lengths are exact multiples of `MORSE_CYCLES` cycles.
- **Total cycles, accept edge to `done_o` rise:** 1 (LOAD) + Σ(mark+gap)·`MORSE_CYCLES`.
- `morse_o` and `done_o` are registered outputs, glitch-free, and never high simultaneously.

## Configuration
- Macro `MORSE_LOWERCASE_EN`:
  - Defined: 'a'–'z' (0x61–0x7A) map to the same patterns as 'A'–'Z'.
  - Undefined: lowercase codes are unsupported (no keying, immediate `done_o`).

## Structure
- Shared package `morse_pkg`:
  - FSM state enum.
  - Unit multipliers: `DOT_UNITS`=1, `DASH_UNITS`=3, `SYM_GAP_UNITS`=1, `WORD_GAP_UNITS`=7.
  - `MORSE_MAX_LEN`=5.
- Sub-module `morse_lut`: pure combinational ASCII → {`len`, `pat`, `is_space`, `valid`}. It holds the lowercase folding under `MORSE_LOWERCASE_EN`.
- The top level holds the FSM, the unit counter and the symbol index.

## Test plan
All scenarios use `MORSE_CYCLES`=2.
- **Reset:** assert `reset_i` 2 cycles → `morse_o`=0, `done_o`=0. With `en_i` high during reset, nothing starts until reset drops.
- **'A' (0x41):** `morse_o` = 1 for 2 cycles, 0 for 2, 1 for 6, 0 for 2. Then `done_o` pulses exactly 1 cycle, at 13 cycles after the accept edge.
- **'9' (0x39):** four × (1 for 6, 0 for 2), then 1 for 2, 0 for 2. `done_o` comes 37 cycles after acceptance.
- **Space (0x20):** `morse_o` stays 0; `done_o` comes at 15 cycles. **'#' (0x23):** `morse_o` stays 0; `done_o` comes at 1 cycle.
- **Mid-character changes:** change `ascii_i` and toggle `en_i` during 'A' → output is unaffected. Holding `en_i` high with 'E' → second 'E' starts the cycle after IDLE.
- **Reset and lowercase:** `reset_i` during the dash of 'A' → `morse_o`=0 next edge, no `done_o`. With `MORSE_LOWERCASE_EN`, 'a' (0x61) is identical to 'A'; without it, `done_o` comes at 1 cycle.
